// File: rtl/fifo_k_pkg.sv
// Shared constants and types for the fifo_k rate-decoupling buffer.
package fifo_k_pkg;
   localparam int FIFO_K_DATA_W = 8;
   localparam int FIFO_K_DEPTH  = 16;

   typedef logic [FIFO_K_DATA_W-1:0] fifo_k_data_t;
endpackage

// File: rtl/fifo_k_mem.sv
// Register-array storage for fifo_k: one synchronous write port, one combinational read port.
module fifo_k_mem
   import fifo_k_pkg::*;
#(
   parameter int DATA_W = FIFO_K_DATA_W,
   parameter int DEPTH  = FIFO_K_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // Contents are deliberately left unreset; the pointers define what is valid.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_k.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and a one-cycle read-valid strobe.
module fifo_k
   import fifo_k_pkg::*;
#(
   parameter int DATA_W = FIFO_K_DATA_W,
   parameter int DEPTH  = FIFO_K_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic              en,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [DATA_W-1:0] data_out
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              en_q, en_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [DATA_W-1:0] rdata;
   logic              wr_ok;
   logic              pop_ok;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                       (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

   // A pop frees a slot on the same edge, so a full FIFO can still take a push alongside it.
   assign pop_ok = pop & ~fifo_empty;
   assign wr_ok  = push & (~fifo_full | pop_ok);

   fifo_k_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (rdata)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      en_d       = 1'b0;
      data_out_d = data_out_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (pop_ok) begin
         rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
         en_d       = 1'b1;
         data_out_d = rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         en_q       <= 1'b0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         en_q       <= en_d;
         data_out_q <= data_out_d;
      end
   end

   assign en       = en_q;
   assign data_out = data_out_q;

endmodule

// File: tb/tb_fifo_k.sv
// Scoreboard bench for fifo_k: queue-based reference model, decoupled monitor on the falling edge.
module tb_fifo_k;
   import fifo_k_pkg::*;

   localparam int DEPTH = FIFO_K_DEPTH;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   fifo_k_data_t data_in = '0;
   logic         en;
   logic         fifo_full;
   logic         fifo_empty;
   fifo_k_data_t data_out;

   int n_vec  = 0;
   int n_fail = 0;

   fifo_k_data_t model_q[$];
   fifo_k_data_t exp_q[$];
   fifo_k_data_t last_val = '0;
   logic         exp_en = 1'b0;
   int           pat = 0;

   fifo_k #(.DATA_W(FIFO_K_DATA_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .data_in    (data_in),
      .en         (en),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Apply one cycle of requests and advance the reference model at the edge.
   task automatic step(input logic p, input logic q, input fifo_k_data_t d);
      logic pop_acc;
      logic push_acc;
      fifo_k_data_t v;
      @(negedge clk);
      #1;
      push    = p;
      pop     = q;
      data_in = d;
      @(posedge clk);
      pop_acc  = q && (model_q.size() > 0);
      push_acc = p && ((model_q.size() < DEPTH) || pop_acc);
      exp_en   = pop_acc;
      if (pop_acc) begin
         v = model_q.pop_front();
         exp_q.push_back(v);
         last_val = v;
      end
      if (push_acc) model_q.push_back(d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      reset = 1'b1;
      model_q.delete();
      exp_q.delete();
      exp_en   = 1'b0;
      last_val = '0;
      #1;
      chk("rst_empty", int'(fifo_empty), 1);
      chk("rst_full", int'(fifo_full), 0);
      chk("rst_en", int'(en), 0);
      chk("rst_data", int'(data_out), 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   always @(negedge clk) begin
      fifo_k_data_t v;
      chk("en", int'(en), int'(exp_en));
      if (en && exp_q.size() > 0) begin
         v = exp_q.pop_front();
         chk("pop_data", int'(data_out), int'(v));
      end else if (!en) begin
         chk("data_hold", int'(data_out), int'(last_val));
      end
      chk("empty", int'(fifo_empty), int'(model_q.size() == 0));
      chk("full", int'(fifo_full), int'(model_q.size() == DEPTH));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      #20;
      @(negedge clk);
      #1 reset = 1'b0;

      do_reset();

      // Basic ordering
      step(1, 0, 8'd5);
      step(1, 0, 8'd9);
      step(1, 0, 8'd9);
      step(0, 1, 8'd0);
      step(1, 0, 8'd45);
      step(0, 1, 8'd0);
      step(0, 1, 8'd0);
      step(0, 0, 8'd0);
      step(0, 0, 8'd0);
      do_reset();

      // Fill, overflow push dropped, drain
      for (int i = 0; i < DEPTH; i++) step(1, 0, fifo_k_data_t'(i));
      step(1, 0, 8'hAA);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'd0);
      step(0, 0, 8'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) step(1, 0, fifo_k_data_t'(i));
      step(1, 1, 8'h77);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'd0);
      step(0, 0, 8'd0);

      // Empty edge cases
      step(0, 1, 8'd0);
      step(1, 1, 8'h33);
      step(0, 1, 8'd0);
      step(0, 0, 8'd0);

      // Wrap-around stream holding 1..4 entries
      step(1, 0, fifo_k_data_t'(pat)); pat++;
      step(1, 0, fifo_k_data_t'(pat)); pat++;
      for (int i = 0; i < 40; i++) begin
         logic p, q;
         if (model_q.size() <= 1)      begin p = 1'b1; q = 1'($urandom_range(0, 1)); end
         else if (model_q.size() >= 4) begin q = 1'b1; p = 1'($urandom_range(0, 1)); end
         else                          begin p = 1'b1; q = 1'b1; end
         step(p, q, fifo_k_data_t'(pat));
         if (p) pat++;
      end
      while (model_q.size() > 0) step(0, 1, 8'd0);
      step(0, 0, 8'd0);

      // Random traffic across full and empty boundaries
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fifo_k_data_t'($urandom));
      end

      // Reset mid-stream with entries stored
      do_reset();
      step(1, 0, 8'h11);
      step(1, 0, 8'h22);
      step(1, 0, 8'h33);
      do_reset();
      step(0, 1, 8'd0);
      step(0, 0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_k.md
Name: fifo_k

Overview:
- Synchronous single-clock FIFO with 8-bit default data width and registered read data.
- Producer writes with `push`; consumer reads with `pop`.
- `en` is a one-cycle strobe qualifying each new value on `data_out`.
- Used as a small rate-decoupling buffer between two blocks in the same clock domain.

Parameters:
- DATA_W, 8, width of `data_in`/`data_out`.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request; `data_in` is sampled on the same edge.
- pop  input  1  read request.
- data_in  input  DATA_W  write data.
- en  output  1  read-valid strobe: high for the one cycle after an accepted pop.
- fifo_full  output  1  high when DEPTH entries are stored.
- fifo_empty  output  1  high when 0 entries are stored.
- data_out  output  DATA_W  registered read data; holds the last popped value.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - wr_ptr=0, rd_ptr=0.
  - fifo_empty=1, fifo_full=0.
  - en=0, data_out=0.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Pointers: ADDR_W+1 bits each. The extra MSB is the wrap bit; both pointers wrap naturally modulo 2*DEPTH.
  - fifo_empty = (wr_ptr == rd_ptr).
  - fifo_full = (index bits equal) AND (wrap bits differ).
  - Flags are combinational from the registered pointers, so they update right after the clock edge that moves a pointer.
- Write accept: wr_ok = push & (~fifo_full | pop_ok).
  - On an edge with wr_ok: mem[wr_ptr index] <= data_in; wr_ptr <= wr_ptr+1.
- Read accept: pop_ok = pop & ~fifo_empty.
  - On an edge with pop_ok: data_out <= mem[rd_ptr index]; rd_ptr <= rd_ptr+1; en <= 1.
  - On any other edge: en <= 0 and data_out holds its value.
- Latency:
  - Data pushed at edge N is poppable from edge N+1 onward.
  - Pop accepted at edge M presents data_out and en=1 from edge M to edge M+1.
- Boundary conditions:
  - Push when full without pop: ignored; no write, full stays 1.
  - Push when full with pop: both accepted; occupancy unchanged, full stays 1.
  - Pop when empty: ignored; en=0, data_out unchanged.
  - Push and pop together when empty: only the push is accepted. There is no write-through bypass. Empty deasserts next cycle.
  - Push and pop together otherwise: both accepted; occupancy unchanged.
  - Continuous push/pop streams are supported at one transfer per cycle each.
- Ordering: strict first-in first-out; no data loss or duplication except for the ignored requests above.

Decomposition:
- Package fifo_k_pkg:
  - Constants FIFO_K_DATA_W=8 and FIFO_K_DEPTH=16.
  - typedef fifo_k_data_t (logic [DATA_W-1:0]).
- Sub-module fifo_k_mem:
  - DEPTH x DATA_W register array.
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port (raddr, rdata).
- fifo_k keeps the pointers, flags, en and the data_out register.

Test Plan:
- Reset: assert reset mid-stream with 3 entries stored → immediately fifo_empty=1, fifo_full=0, en=0, data_out=0; a following pop is ignored.
- Basic order: push 5, 9, 9 on three consecutive edges; pop one cycle → data_out=5 with en=1 for exactly one cycle. Push 45; pop → 9; pop → 9. One entry remains (45), fifo_empty=0; data_out holds 9 with en=0 afterwards.
- Fill: push 0..15 with no pop → fifo_full=1 after the 16th edge. A 17th push of 0xAA is dropped; draining yields 0..15 in order, then fifo_empty=1.
- Full with simultaneous push/pop: when full, push 0x77 with pop → data_out=0 (oldest entry), fifo_full stays 1, and 0x77 is popped last.
- Empty edge cases:
  - Pop on empty → en=0, data_out unchanged.
  - Push 0x33 with pop on empty → en=0; next-cycle pop returns 0x33.
- Wrap-around: 40 cycles of continuous push/pop with 1 to 4 entries stored, using an incrementing pattern → output sequence is an exact incrementing match; flags stay correct across pointer wrap.
